// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter sharing one sync FIFO write port
// Optional build macro FIFO_ARB_PRIO_EN: requester 0 wins every arbitration point.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DWIDTH    = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DWIDTH-1:0]    req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic                         fifo_full,
  output logic                         fifo_wr_en,
  output logic [DWIDTH-1:0]            fifo_din,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         busy
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t          r_state;
  logic [GW-1:0]   r_grant_id;
  logic [GW-1:0]   r_last_grant;
  logic [BW-1:0]   r_beat_cnt;

  state_t          w_state_nxt;
  logic [GW-1:0]   w_grant_nxt;
  logic [GW-1:0]   w_last_nxt;
  logic [BW-1:0]   w_cnt_nxt;
  logic            w_release;
  logic            w_owner_valid;
  logic            w_xfer;
  logic [DWIDTH-1:0] w_slices [NUM_REQ];

  // First valid index after base in rotating order; base itself is checked last.
  function automatic logic [GW-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                            input logic [GW-1:0]      base);
    logic [GW-1:0] pick;
    logic [GW-1:0] idx_g;
    int            idx;
    pick = base;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx   = (int'(base) + i) % NUM_REQ;
      idx_g = GW'(idx);
      if (v[idx_g]) pick = idx_g;
    end
`ifdef FIFO_ARB_PRIO_EN
    if (v[0]) pick = '0;
`endif
    return pick;
  endfunction

  // State register: grant owner, rotation pointer and beat counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_grant_id   <= '0;
      r_last_grant <= GW'(NUM_REQ - 1);
      r_beat_cnt   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_grant_id   <= w_grant_nxt;
      r_last_grant <= w_last_nxt;
      r_beat_cnt   <= w_cnt_nxt;
    end
  end

  // Next state: pick from IDLE, count beats, and hand over without a bubble on release.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant_id;
    w_last_nxt  = r_last_grant;
    w_cnt_nxt   = r_beat_cnt;
    w_release   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|req_valid) begin
          w_grant_nxt = rr_pick(req_valid, r_last_grant);
          w_cnt_nxt   = '0;
          w_state_nxt = S_BURST;
        end
      end
      S_BURST: begin
        w_release = (w_xfer && (r_beat_cnt == BW'(MAX_BURST - 1))) || !w_owner_valid;
        if (w_xfer) w_cnt_nxt = r_beat_cnt + 1'b1;
        if (w_release) begin
          w_last_nxt = r_grant_id;
          w_cnt_nxt  = '0;
          if (|req_valid) begin
            w_grant_nxt = rr_pick(req_valid, r_grant_id);
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs: pure data mux from the owner, write only when the FIFO has room.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_slices[i] = req_data[i*DWIDTH +: DWIDTH];
    end
    busy          = (r_state == S_BURST);
    grant_id      = r_grant_id;
    w_owner_valid = req_valid[r_grant_id];
    w_xfer        = busy && w_owner_valid && !fifo_full;
    fifo_wr_en    = w_xfer && !rst;
    fifo_din      = w_slices[r_grant_id];
    req_ready     = '0;
    if (busy && !fifo_full && !rst) begin
      req_ready = NUM_REQ'(1) << r_grant_id;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [15:0] req_data;
  logic [3:0]  req_ready;
  logic        fifo_full;
  logic        fifo_wr_en;
  logic [3:0]  fifo_din;
  logic [1:0]  grant_id;
  logic        busy;

  int n_vec;
  int n_err;

  fifo_wr_arbiter #(.NUM_REQ(4), .DWIDTH(4), .MAX_BURST(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .fifo_full  (fifo_full),
    .fifo_wr_en (fifo_wr_en),
    .fifo_din   (fifo_din),
    .grant_id   (grant_id),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = 4'b0000;
    fifo_full = 1'b0;
    next_cyc();
    next_cyc();
    rst = 1'b0;
  endtask

  initial begin
    logic [1:0] exp_g;
    n_vec     = 0;
    n_err     = 0;
    rst       = 1'b1;
    req_valid = 4'hF;
    req_data  = 16'h3210;
    fifo_full = 1'b0;

    // reset with everybody valid
    next_cyc();
    mid();
    chk("t1_rst_ready", req_ready, 4'b0000);
    chk("t1_rst_wr_en", fifo_wr_en, 1'b0);
    chk("t1_rst_busy", busy, 1'b0);
    chk("t1_rst_grant", grant_id, 2'd0);
    next_cyc();
    mid();
    chk("t1_rst2_ready", req_ready, 4'b0000);
    chk("t1_rst2_wr_en", fifo_wr_en, 1'b0);
    next_cyc();
    rst = 1'b0;
    mid();
    chk("t1_idle_wr_en", fifo_wr_en, 1'b0);
    chk("t1_idle_busy", busy, 1'b0);
    next_cyc();
    mid();
    chk("t1_first_grant", grant_id, 2'd0);
    chk("t1_first_ready", req_ready, 4'b0001);
    chk("t1_first_busy", busy, 1'b1);

    // single requester: continuous writes, back-to-back re-grant
    do_reset();
    req_valid = 4'b0100;
    req_data  = 16'h0A00;
    mid();
    chk("t2_idle_wr_en", fifo_wr_en, 1'b0);
    for (int k = 1; k <= 9; k++) begin
      next_cyc();
      mid();
      chk($sformatf("t2_grant_%0d", k), grant_id, 2'd2);
      chk($sformatf("t2_wr_en_%0d", k), fifo_wr_en, 1'b1);
      chk($sformatf("t2_din_%0d", k), fifo_din, 4'hA);
      if (k == 1) chk("t2_ready", req_ready, 4'b0100);
    end

    // all valid: owner rotation 0000111122223333...
    do_reset();
    req_valid = 4'hF;
    req_data  = 16'h3210;
    mid();
    chk("t3_idle_wr_en", fifo_wr_en, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      exp_g = 2'(((k - 1) / 4) % 4);
      next_cyc();
      mid();
      chk($sformatf("t3_din_%0d", k), fifo_din, exp_g);
      chk($sformatf("t3_grant_%0d", k), grant_id, exp_g);
      chk($sformatf("t3_wr_en_%0d", k), fifo_wr_en, 1'b1);
    end
    // reset mid-burst
    next_cyc();
    rst = 1'b1;
    mid();
    chk("t3_midrst_wr_en", fifo_wr_en, 1'b0);
    chk("t3_midrst_ready", req_ready, 4'b0000);
    next_cyc();
    mid();
    chk("t3_midrst_busy", busy, 1'b0);
    chk("t3_midrst_grant", grant_id, 2'd0);

    // full stall after two beats
    do_reset();
    req_valid = 4'b1010;
    req_data  = 16'hC0B0;
    mid();
    next_cyc();
    mid();
    chk("t4_b0_grant", grant_id, 2'd1);
    chk("t4_b0_din", fifo_din, 4'hB);
    chk("t4_b0_wr_en", fifo_wr_en, 1'b1);
    next_cyc();
    mid();
    chk("t4_b1_wr_en", fifo_wr_en, 1'b1);
    for (int k = 3; k <= 7; k++) begin
      next_cyc();
      fifo_full = 1'b1;
      mid();
      chk($sformatf("t4_stall_wr_en_%0d", k), fifo_wr_en, 1'b0);
      chk($sformatf("t4_stall_ready_%0d", k), req_ready, 4'b0000);
      chk($sformatf("t4_stall_grant_%0d", k), grant_id, 2'd1);
      chk($sformatf("t4_stall_busy_%0d", k), busy, 1'b1);
    end
    next_cyc();
    fifo_full = 1'b0;
    mid();
    chk("t4_b2_wr_en", fifo_wr_en, 1'b1);
    chk("t4_b2_grant", grant_id, 2'd1);
    next_cyc();
    mid();
    chk("t4_b3_wr_en", fifo_wr_en, 1'b1);
    chk("t4_b3_grant", grant_id, 2'd1);
    next_cyc();
    mid();
    chk("t4_release_grant", grant_id, 2'd3);
    chk("t4_release_din", fifo_din, 4'hC);

    // valid drop mid-burst
    do_reset();
    req_valid = 4'b1010;
    req_data  = 16'hC0B0;
    mid();
    next_cyc();
    mid();
    chk("t5_b0_grant", grant_id, 2'd1);
    next_cyc();
    req_valid = 4'b1000;
    mid();
    chk("t5_drop_wr_en", fifo_wr_en, 1'b0);
    chk("t5_drop_grant", grant_id, 2'd1);
    chk("t5_drop_ready", req_ready, 4'b0010);
    next_cyc();
    req_valid = 4'b1010;
    mid();
    chk("t5_new_din", fifo_din, 4'hC);
    chk("t5_new_wr_en", fifo_wr_en, 1'b1);
    for (int k = 3; k <= 6; k++) begin
      if (k > 3) begin
        next_cyc();
        mid();
      end
      chk($sformatf("t5_own3_grant_%0d", k), grant_id, 2'd3);
    end
    next_cyc();
    mid();
    chk("t5_rr_turn_grant", grant_id, 2'd1);
    chk("t5_rr_turn_din", fifo_din, 4'hB);

    // requester 0 rises during requester 2's burst
`ifdef FIFO_ARB_PRIO_EN
    exp_g = 2'd0;
`else
    exp_g = 2'd3;
`endif
    do_reset();
    req_valid = 4'b1100;
    req_data  = 16'hDC0E;
    mid();
    next_cyc();
    mid();
    chk("t6_b0_grant", grant_id, 2'd2);
    chk("t6_b0_din", fifo_din, 4'hC);
    next_cyc();
    req_valid = 4'b1101;
    mid();
    chk("t6_b1_grant", grant_id, 2'd2);
    for (int k = 3; k <= 4; k++) begin
      next_cyc();
      mid();
      chk($sformatf("t6_b%0d_grant", k - 1), grant_id, 2'd2);
    end
    for (int k = 5; k <= 8; k++) begin
      next_cyc();
      mid();
      chk($sformatf("t6_next_grant_%0d", k), grant_id, exp_g);
      chk($sformatf("t6_next_wr_en_%0d", k), fifo_wr_en, 1'b1);
    end
    next_cyc();
    mid();
    chk("t6_after_grant", grant_id, 2'd0);
    chk("t6_after_din", fifo_din, 4'hE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
